// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage.
// State encoding, register-number width and default widths.
package writeback_stage_pkg;

   localparam int MIP_BUS_DEF = 32;
   localparam int RA_REG_DEF  = 31;
   localparam int REG_W       = 5;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_LOAD = 2'd1,
      COMMIT    = 2'd2
   } state_t;

endpackage

// File: rtl/writeback_result_mux.sv
// Writeback result select: link address, load data, then ALU result.
module writeback_result_mux #(
   parameter int MIP_BUS = 32
) (
   input  logic               is_jal,
   input  logic               mem_to_reg,
   input  logic [MIP_BUS-1:0] alu_result,
   input  logic [MIP_BUS-1:0] link_addr,
   input  logic [MIP_BUS-1:0] load_data,
   output logic [MIP_BUS-1:0] result
);

   always_comb begin
      result = alu_result;
      if (is_jal)
         result = link_addr;
      else if (mem_to_reg)
         result = load_data;
   end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires MEM results into the register file,
// stalling for late load data and providing a forwarding copy.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int MIP_BUS = MIP_BUS_DEF,
   parameter int RA_REG  = RA_REG_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wb_valid_i,
   output logic               wb_ready_o,
   input  logic               reg_write_i,
   input  logic [REG_W-1:0]   dest_i,
   input  logic               is_jal_i,
   input  logic               mem_to_reg_i,
   input  logic [MIP_BUS-1:0] alu_result_i,
   input  logic [MIP_BUS-1:0] link_addr_i,
   input  logic [MIP_BUS-1:0] load_data_i,
   input  logic               load_valid_i,
   output logic               RegWrite,
   output logic [REG_W-1:0]   Write_register,
   output logic [MIP_BUS-1:0] Write_data,
   output logic               fwd_valid_o,
   output logic [REG_W-1:0]   fwd_reg_o,
   output logic [MIP_BUS-1:0] fwd_data_o,
   output logic [31:0]        retired_o
);

   localparam logic [REG_W-1:0] RA = REG_W'(RA_REG);

   state_t             state;
   logic               c_we;
   logic               c_jal;
   logic               c_m2r;
   logic [REG_W-1:0]   c_dest;
   logic [MIP_BUS-1:0] c_alu;
   logic [MIP_BUS-1:0] c_link;

   logic               xfer;
   logic               live;
   logic               fire;
   logic               s_we;
   logic               s_jal;
   logic               s_m2r;
   logic [REG_W-1:0]   s_dest;
   logic [MIP_BUS-1:0] s_alu;
   logic [MIP_BUS-1:0] s_link;
   logic [REG_W-1:0]   dest_eff;
   logic               we_eff;
   logic [MIP_BUS-1:0] result;

   assign wb_ready_o = (state != WAIT_LOAD);
   assign xfer       = wb_valid_i & wb_ready_o;
   assign live       = (state != WAIT_LOAD);

   // Operands come from the live inputs on transfer, from the holding
   // registers while a load is outstanding.
   assign s_we   = live ? reg_write_i  : c_we;
   assign s_jal  = live ? is_jal_i     : c_jal;
   assign s_m2r  = live ? mem_to_reg_i : c_m2r;
   assign s_dest = live ? dest_i       : c_dest;
   assign s_alu  = live ? alu_result_i : c_alu;
   assign s_link = live ? link_addr_i  : c_link;

   assign fire = live ? (xfer & ~(mem_to_reg_i & ~load_valid_i))
                      : load_valid_i;

   assign dest_eff = s_jal ? RA : s_dest;
   assign we_eff   = (s_we | s_jal) & (dest_eff != '0);

   writeback_result_mux #(
      .MIP_BUS (MIP_BUS)
   ) u_mux (
      .is_jal     (s_jal),
      .mem_to_reg (s_m2r),
      .alu_result (s_alu),
      .link_addr  (s_link),
      .load_data  (load_data_i),
      .result     (result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         c_we           <= 1'b0;
         c_jal          <= 1'b0;
         c_m2r          <= 1'b0;
         c_dest         <= '0;
         c_alu          <= '0;
         c_link         <= '0;
         RegWrite       <= 1'b0;
         Write_register <= '0;
         Write_data     <= '0;
         retired_o      <= '0;
      end else begin
         RegWrite <= 1'b0;
         if (state == COMMIT)
            retired_o <= retired_o + 32'd1;
         if (fire) begin
            RegWrite       <= we_eff;
            Write_register <= dest_eff;
            Write_data     <= result;
         end
         case (state)
            WAIT_LOAD: begin
               if (load_valid_i)
                  state <= COMMIT;
            end
            default: begin
               if (xfer) begin
                  c_we   <= reg_write_i;
                  c_jal  <= is_jal_i;
                  c_m2r  <= mem_to_reg_i;
                  c_dest <= dest_i;
                  c_alu  <= alu_result_i;
                  c_link <= link_addr_i;
                  state  <= fire ? COMMIT : WAIT_LOAD;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign fwd_valid_o = RegWrite;
   assign fwd_reg_o   = Write_register;
   assign fwd_data_o  = Write_data;

endmodule
